rr_burst_arbiter: RTL
=====================

// Module: rr_burst_arbiter
// PURPOSE
//  Shares one downstream valid/ready stream among N upstream requesters, one whole burst
//  at a time. Picks requesters round-robin, starting the search just after the last winner.
//  The grant is locked until the granted source sends a beat with last set.
//  A data/last mux drives the shared port. Sits between N bus masters and a single
//  shared resource port (e.g. memory or CSR channel).
// PARAMETERS
//  N         8    number of requesters (>=2)
//  DATA_W    32   beat payload width
//  MAX_BEATS 16   watchdog limit: longest burst allowed before a forced release (>=2)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         async active-low reset
//  req_valid  in   N         per-requester beat valid
//  req_last   in   N         per-requester last-beat flag, qualified by req_valid
//  req_data   in   N*DATA_W  per-requester payload; slice i = [i*DATA_W +: DATA_W]
//  req_ready  out  N         per-requester ready; only the granted bit can be 1
//  out_valid  out  1         shared-port valid
//  out_last   out  1         shared-port last
//  out_data   out  DATA_W    shared-port payload
//  out_id     out  clog2(N)  index of the current grant holder
//  out_ready  in   1         shared-port ready
//  gnt        out  N         registered one-hot grant; 0 when idle
//  burst_err  out  1         sticky: watchdog fired since reset
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//  - state=IDLE, gnt=0, ptr=N-1 (first search starts at index 0).
//  - beat_cnt=0, burst_err=0, out_id=0.
//  - Outputs derived from gnt are therefore 0: out_valid, req_ready, out_last.
//  FSM IDLE:
//  - If |req_valid, the winner is the first set bit at ptr+1..N-1, else wrapping to 0..ptr.
//  - Register gnt<=onehot(winner), out_id<=winner, ptr<=winner, beat_cnt<=0, go LOCKED.
//  - If no request, stay IDLE with gnt=0.
//  FSM LOCKED, grant g:
//  - out_valid=req_valid[g], out_last=req_last[g], out_data=req_data[g].
//  - req_ready[g]=out_ready; all other req_ready bits are 0.
//  - Transfer = out_valid & out_ready; each transfer increments beat_cnt.
//  - Transfer with out_last: go IDLE, gnt<=0.
//  - Transfer without last at beat_cnt==MAX_BEATS-1: go IDLE, gnt<=0, burst_err<=1.
//  - Otherwise hold the lock. req_valid[g] low means a bubble, not a release.
//  Latency:
//  - Request seen in IDLE at cycle t gives gnt at t+1; the first beat can transfer at t+1.
//  - After a release there is one IDLE cycle (arbitration bubble) before the next grant.
//  - Peak throughput: B beats per B+1 cycles.
//  Boundaries:
//  - Single-beat burst (last on first beat): LOCKED for 1 cycle.
//  - Other requesters asserting or dropping valid while locked has no effect on the grant.
//  - ptr=N-1 wraps the search to 0. A lone requester equal to ptr wins again (no starvation).
//  - Reset mid-burst drops the grant immediately; no partial-burst completion.
//  - out_ready low stalls indefinitely; the watchdog counts beats, not cycles.
//  - out_* are combinational from registered gnt/out_id and the inputs.
//  - No combinational path from req_valid to gnt.
// STRUCTURE
//  - Package rr_arb_pkg: state enum {IDLE, LOCKED}, clog2 width helper function.
//  - Sub-module rr_priority_pick (combinational):
//    - inputs: req[N], ptr onehot[N]; output: onehot pick[N].
//    - Mask out bits at and below ptr; fall back to the unmasked request vector if the
//      masked vector is 0; take the lowest set bit via x & -x.
//  - Top level: FSM, ptr/beat_cnt/burst_err registers, one-hot to index encoder,
//    data/last mux.
// TESTING (N=4, DATA_W=32, MAX_BEATS=4 unless noted)
//  1 After reset req_valid=4'b1111, all bursts 1 beat, out_ready=1:
//    -> grants 0,1,2,3,0 on every other cycle; out_id follows.
//  2 Req 2 sends 3 beats (last on beat 3) while req 0 raises valid mid-burst:
//    -> 3 beats of req 2 are contiguous on out_data; 1 idle cycle; then gnt=4'b0001.
//  3 out_ready held low 5 cycles during a burst from req 1:
//    -> out_data stable, req_ready=0, gnt stays 4'b0010; beats resume in order.
//  4 Req 3 sends 4 beats, none with last:
//    -> forced release after beat 4; burst_err=1 and stays 1; next arbitration starts at 0.
//  5 Only req 3 active, ptr=3:
//    -> req 3 re-granted every burst (wrap); then req 0 and 3 both active -> 0 wins.
//  6 rst_n asserted during the 2nd beat of a burst:
//    -> gnt=0, out_valid=0, burst_err=0 the same cycle; after release, grant goes to 0 first.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
//   state_e : arbiter FSM state (IDLE searching, LOCKED on one source)
//   clog2w  : index width helper, never returns less than 1 bit
package rr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
//   i_req  : request vector
//   i_ptr  : one-hot last winner; the search starts just above it
//   o_pick : one-hot winner, 0 when i_req is 0
module rr_priority_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_ptr,
  output logic [N-1:0] o_pick
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] w_mask, w_masked, w_sel;

  // ptr | (ptr-1) covers ptr and everything below it; keep only bits above
  assign w_mask   = ~(i_ptr | (i_ptr - ONE));
  assign w_masked = i_req & w_mask;
  // nothing above ptr -> wrap around to the full request vector
  assign w_sel    = (|w_masked) ? w_masked : i_req;
  // isolate lowest set bit (x & -x)
  assign o_pick   = w_sel & (~w_sel + ONE);

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: N valid/ready sources share one output stream,
// one whole burst at a time. The grant is held until the owner sends a beat
// with last set, or until a watchdog forces release after MAX_BEATS beats.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/last/data  : per-source beat stream (data slice i = [i*DATA_W +: DATA_W])
//   req_ready            : per-source ready, only the granted bit can be 1
//   out_valid/last/data  : shared output stream, out_ready is its backpressure
//   out_id               : index of the current/last grant holder
//   gnt                  : registered one-hot grant, 0 when idle
//   burst_err            : sticky watchdog flag
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N-1:0]           req_last,
  input  logic [N*DATA_W-1:0]    req_data,
  output logic [N-1:0]           req_ready,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [DATA_W-1:0]      out_data,
  output logic [clog2w(N)-1:0]   out_id,
  input  logic                   out_ready,
  output logic [N-1:0]           gnt,
  output logic                   burst_err
);

  localparam int IDW = clog2w(N);
  localparam int CW  = clog2w(MAX_BEATS);
  // ptr resets to N-1 so the first search begins at index 0
  localparam logic [N-1:0] PTR_RST = {1'b1, {(N-1){1'b0}}};

  state_e            r_state, w_state_nxt;
  logic [N-1:0]      r_gnt, w_gnt_nxt;
  logic [N-1:0]      r_ptr, w_ptr_nxt;
  logic [IDW-1:0]    r_id, w_id_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [N-1:0]      w_pick;
  logic [IDW-1:0]    w_pick_id;
  logic [DATA_W-1:0] w_data;
  logic              w_xfer;

  rr_priority_pick #(.N(N)) u_pick (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick)
  );

  always_comb begin
    w_pick_id = '0;
    for (int i = 0; i < N; i++)
      if (w_pick[i]) w_pick_id = IDW'(i);
  end

  // AND-OR mux on the one-hot grant; reads 0 while idle
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++)
      if (r_gnt[i]) w_data = w_data | req_data[i*DATA_W +: DATA_W];
  end

  assign out_valid = |(req_valid & r_gnt);
  assign out_last  = |(req_last & r_gnt);
  assign out_data  = w_data;
  assign out_id    = r_id;
  assign req_ready = r_gnt & {N{out_ready}};
  assign gnt       = r_gnt;
  assign burst_err = r_err;
  assign w_xfer    = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_state_nxt = LOCKED;
          w_gnt_nxt   = w_pick;
          w_ptr_nxt   = w_pick;
          w_id_nxt    = w_pick_id;
          w_cnt_nxt   = '0;
        end
      end
      LOCKED: begin
        // watchdog counts accepted beats only; stalls and bubbles are free
        if (w_xfer) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (out_last) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end else if (r_cnt == CW'(MAX_BEATS - 1)) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_err_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= PTR_RST;
      r_id    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule
